ps2_kbd_rx: RTL and testbench
=============================

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: receive FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter TIMEOUT_CYCLES, default 200000: clk cycles without a ps2_clk falling edge that abort a frame in progress.
REQ-003 Port clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port ps2_clk  input  1  asynchronous PS/2 clock line from the keyboard.
REQ-006 Port ps2_data  input  1  asynchronous PS/2 data line from the keyboard.
REQ-007 Port kbd_read_enable  input  1  consumer pop strobe, one byte per asserted cycle.
REQ-008 Port kbd_data  output  8  FIFO head byte (show-ahead); valid only while kbd_ready=1.
REQ-009 Port kbd_ready  output  1  FIFO non-empty.
REQ-010 Port kbd_overflow  output  1  sticky flag: a received byte was dropped.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass a 2-flop synchronizer; a falling edge SHALL be detected when the synchronized ps2_clk changes from 1 to 0.
REQ-012 Bits SHALL be sampled from synchronized ps2_data only on the cycle of a detected falling edge.
REQ-013 Frame = start(0), 8 data bits LSB first, odd parity, stop(1); 11 falling edges per frame.
REQ-014 FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on a falling edge with data=0 go to DATA and clear the bit counter; a falling edge with data=1 SHALL be ignored (stay IDLE).
REQ-016 DATA: shift each sampled bit into bit[count]; after the 8th bit go to PARITY.
REQ-017 PARITY: sample the parity bit, then go to STOP.
REQ-018 STOP: on a falling edge, if stop=1 and XOR(data,parity)=1, push the byte; in all cases go to IDLE.
REQ-019 A frame failing the parity or stop check SHALL be discarded silently, with no FIFO change and no flag change.
REQ-020 Timeout counter: cleared on every falling edge and while in IDLE; when it reaches TIMEOUT_CYCLES outside IDLE, the FSM SHALL return to IDLE and discard the partial byte.
REQ-021 Push latency: kbd_ready SHALL be 1 on the cycle after the STOP-edge cycle, when the FIFO was empty.
REQ-022 Pop: kbd_read_enable=1 with kbd_ready=1 removes the head at that edge, and kbd_data shows the next entry on the following cycle.
REQ-023 kbd_read_enable while kbd_ready=0 SHALL have no effect.
REQ-024 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; occupancy is unchanged and overflow is not set.
REQ-025 Push when full without a simultaneous pop SHALL drop the new byte, leave the FIFO contents intact, and set kbd_overflow.
REQ-026 kbd_overflow SHALL clear on the cycle after a successful pop, unless that same cycle also sets it.
REQ-027 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo depth; an occupancy counter of log2(FIFO_DEPTH)+1 bits SHALL distinguish full from empty.

Reset
REQ-028 While rst=1: FSM to IDLE; bit counter, shift register, timeout counter, pointers and occupancy to 0; kbd_ready=0, kbd_overflow=0, kbd_data=0; synchronizer flops to 1 (line idle).
REQ-029 Reset asserted mid-frame SHALL abandon the frame; the first frame completed after reset is accepted normally.
REQ-030 FIFO storage contents need no reset; kbd_data SHALL read 0 while the FIFO is empty.

Structure
REQ-031 Package kbd_pkg SHALL hold the FSM state enum, the frame length constant (11) and the default parameter values.
REQ-032 The FIFO SHALL be a separate sub-module kbd_fifo (show-ahead sync FIFO with push, pop, full, empty, count outputs); ps2_kbd_rx instantiates it once.

Verification
REQ-033 Send a valid frame for 0x1C (parity 0) -> kbd_ready=1 one cycle after the stop edge, kbd_data=0x1C; pop -> kbd_ready=0.
REQ-034 Send 0x1C with parity bit 1 -> kbd_ready stays 0; then send a valid 0x32 -> kbd_data=0x32.
REQ-035 Send 9 valid frames (0x01..0x09) without popping, FIFO_DEPTH=8 -> kbd_overflow=1; pops return 0x01..0x08 in order; kbd_overflow=0 after the first pop.
REQ-036 Stop ps2_clk after 5 bits for TIMEOUT_CYCLES (set to 100) -> FSM returns to IDLE; a following valid frame 0xF0 is received correctly.
REQ-037 With the FIFO full, time the 9th frame's stop edge to the same cycle as a pop -> occupancy stays 8, kbd_overflow=0, and the last entry equals the new byte.
REQ-038 Assert rst for 1 cycle after bit 4 of a frame, then send valid 0xAA -> only 0xAA is received, with kbd_ready=1 and kbd_overflow=0.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds the frame FSM state enum, the frame geometry and the default parameter values.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rxState_e;

    localparam int FRAME_BITS             = 11;
    localparam int DATA_BITS              = FRAME_BITS - 3;
    localparam int DEFAULT_FIFO_DEPTH     = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

endpackage

// File: rtl/kbd_fifo.sv
// Show-ahead synchronous FIFO for received scan-code bytes.
// A push into a full FIFO only lands when a pop happens on the same cycle.
module kbd_fifo
    import kbd_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter  int WIDTH = DATA_BITS,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pushEff;
    logic             popEff;

    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

    assign popEff  = pop_i & ~empty_o;
    assign pushEff = push_i & (~full_o | popEff);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushEff) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popEff) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({pushEff, popEff})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left unreset; empty_o masks stale contents on data_o.
    always_ff @(posedge clk_i) begin
        if (pushEff) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes the PS/2 lines, deframes 11-bit frames on
// ps2_clk falling edges, checks odd parity and stop, and queues bytes in a FIFO.
module ps2_kbd_rx
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    input  logic                 kbd_read_enable,
    output logic [DATA_BITS-1:0] kbd_data,
    output logic                 kbd_ready,
    output logic                 kbd_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = $clog2(DATA_BITS);

    logic [1:0]           ps2ClkSync_q;
    logic [1:0]           ps2DataSync_q;
    logic                 ps2ClkPrev_q;
    logic                 fallEdge;
    logic                 bitData;

    rxState_e             state_q, state_d;
    logic [CNT_W-1:0]     bitCount_q, bitCount_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [TO_W-1:0]      timeout_q, timeout_d;
    logic                 overflow_q, overflow_d;
    logic                 pushByte;

    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [PTR_W:0]       fifoCount;
    logic                 popEff;
    logic                 dropByte;

    // Synchronizers reset to 1 so an idle line never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2ClkSync_q  <= 2'b11;
            ps2DataSync_q <= 2'b11;
            ps2ClkPrev_q  <= 1'b1;
        end else begin
            ps2ClkSync_q  <= {ps2ClkSync_q[0], ps2_clk};
            ps2DataSync_q <= {ps2DataSync_q[0], ps2_data};
            ps2ClkPrev_q  <= ps2ClkSync_q[1];
        end
    end

    assign fallEdge = ps2ClkPrev_q & ~ps2ClkSync_q[1];
    assign bitData  = ps2DataSync_q[1];

    always_comb begin
        state_d    = state_q;
        bitCount_d = bitCount_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        timeout_d  = timeout_q + TO_W'(1);
        pushByte   = 1'b0;
        if (state_q == IDLE || fallEdge) begin
            timeout_d = '0;
        end
        if (fallEdge) begin
            case (state_q)
                IDLE: begin
                    if (!bitData) begin
                        state_d    = DATA;
                        bitCount_d = '0;
                    end
                end
                DATA: begin
                    shift_d[bitCount_q] = bitData;
                    bitCount_d          = bitCount_q + CNT_W'(1);
                    if (bitCount_q == CNT_W'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = bitData;
                    state_d  = STOP;
                end
                STOP: begin
                    pushByte = bitData & (^{shift_q, parity_q});
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && timeout_q == TO_W'(TIMEOUT_CYCLES)) begin
            // A stalled keyboard clock abandons the partial frame.
            state_d    = IDLE;
            bitCount_d = '0;
            shift_d    = '0;
            timeout_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bitCount_q <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            timeout_q  <= '0;
        end else begin
            state_q    <= state_d;
            bitCount_q <= bitCount_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            timeout_q  <= timeout_d;
        end
    end

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) uFifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (pushByte),
        .data_i  (shift_q),
        .pop_i   (kbd_read_enable),
        .data_o  (kbd_data),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    assign kbd_ready    = ~fifoEmpty;
    assign popEff       = kbd_read_enable & ~fifoEmpty;
    assign dropByte     = pushByte & fifoFull & ~popEff;
    assign kbd_overflow = overflow_q;

    always_comb begin
        overflow_d = overflow_q;
        if (dropByte) begin
            overflow_d = 1'b1;
        end else if (popEff) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        fifoFull == (fifoCount == (PTR_W + 1)'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: stimulus sends PS/2 frames and queues expected
// bytes; a monitor pops the DUT FIFO and compares each head byte against the queue.
module tb_ps2_kbd_rx;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       kbd_read_enable;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_overflow;

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] sb [$];
    logic       autoPop = 1'b0;
    logic       popReq  = 1'b0;
    logic       rawRe   = 1'b0;

    ps2_kbd_rx #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ps2_clk         (ps2_clk),
        .ps2_data        (ps2_data),
        .kbd_read_enable (kbd_read_enable),
        .kbd_data        (kbd_data),
        .kbd_ready       (kbd_ready),
        .kbd_overflow    (kbd_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [10:0] makeFrame(input logic [7:0] d, input logic badParity);
        return {1'b1, (~^d) ^ badParity, d, 1'b0};
    endfunction

    task automatic ps2Bit(input logic b);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic sendBits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2Bit(f[i]);
        end
    endtask

    task automatic stopFall();
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
    endtask

    task automatic releaseClk(input int held);
        repeat (8 - held) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic badParity, input logic expectPush);
        if (expectPush) sb.push_back(d);
        sendBits(makeFrame(d, badParity), 10);
        stopFall();
        releaseClk(0);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || kbd_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "Left"}, sb.size(), 0);
        checkOutput({name, "Ready"}, {31'd0, kbd_ready}, 0);
    endtask

    // Monitor: pops whenever allowed and compares the head byte with the scoreboard.
    initial begin
        logic       popNow;
        logic [7:0] expByte;
        kbd_read_enable = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            popNow = (autoPop || popReq) && kbd_ready && !rst;
            if (popNow) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedByte: got 0x%0h, expected no byte", kbd_data);
                end else begin
                    expByte = sb.pop_front();
                    checkOutput("popData", {24'd0, kbd_data}, {24'd0, expByte});
                end
            end
            kbd_read_enable = popNow | rawRe;
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 1ms");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("resetReady", {31'd0, kbd_ready}, 0);
        checkOutput("resetOverflow", {31'd0, kbd_overflow}, 0);
        checkOutput("resetData", {24'd0, kbd_data}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] read strobes on an empty FIFO");
        rawRe = 1'b1;
        repeat (3) @(negedge clk);
        rawRe = 1'b0;
        @(negedge clk);
        checkOutput("emptyPopReady", {31'd0, kbd_ready}, 0);
        checkOutput("emptyPopData", {24'd0, kbd_data}, 0);

        $display("[TB] single frame 0x1C with latency check");
        autoPop = 1'b1;
        sb.push_back(8'h1C);
        sendBits(makeFrame(8'h1C, 1'b0), 10);
        stopFall();
        repeat (2) @(negedge clk);
        checkOutput("latencyEarly", {31'd0, kbd_ready}, 0);
        @(negedge clk);
        checkOutput("latencyReady", {31'd0, kbd_ready}, 1);
        checkOutput("headData", {24'd0, kbd_data}, 32'h1C);
        releaseClk(3);
        waitDrain("drain1C");

        $display("[TB] bad parity frame then 0x32");
        applyStimulus(8'h1C, 1'b1, 1'b0);
        checkOutput("badParityReady", {31'd0, kbd_ready}, 0);
        applyStimulus(8'h32, 1'b0, 1'b1);
        waitDrain("drain32");

        $display("[TB] overflow with nine frames");
        autoPop = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(8'(i), 1'b0, i <= 8);
        end
        checkOutput("ovfSet", {31'd0, kbd_overflow}, 1);
        checkOutput("ovfHead", {24'd0, kbd_data}, 32'h01);
        autoPop = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("ovfClearAfterPop", {31'd0, kbd_overflow}, 0);
        waitDrain("drainOvf");

        $display("[TB] timeout after five bits then 0xF0");
        sendBits(makeFrame(8'h3C, 1'b0), 5);
        repeat (130) @(negedge clk);
        checkOutput("timeoutReady", {31'd0, kbd_ready}, 0);
        applyStimulus(8'hF0, 1'b0, 1'b1);
        waitDrain("drainF0");

        $display("[TB] push and pop on the same cycle while full");
        autoPop = 1'b0;
        for (int i = 8'h11; i <= 8'h18; i++) begin
            applyStimulus(8'(i), 1'b0, 1'b1);
        end
        checkOutput("fullNoOverflow", {31'd0, kbd_overflow}, 0);
        sb.push_back(8'h19);
        sendBits(makeFrame(8'h19, 1'b0), 10);
        stopFall();
        repeat (2) @(negedge clk);
        popReq = 1'b1;
        @(negedge clk);
        popReq = 1'b0;
        checkOutput("simulOverflow", {31'd0, kbd_overflow}, 0);
        checkOutput("simulReady", {31'd0, kbd_ready}, 1);
        releaseClk(3);
        autoPop = 1'b1;
        waitDrain("drainSimul");

        $display("[TB] reset mid-frame then 0xAA");
        autoPop = 1'b0;
        sendBits(makeFrame(8'h55, 1'b0), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(8'hAA, 1'b0, 1'b1);
        checkOutput("afterRstReady", {31'd0, kbd_ready}, 1);
        checkOutput("afterRstData", {24'd0, kbd_data}, 32'hAA);
        checkOutput("afterRstOverflow", {31'd0, kbd_overflow}, 0);
        autoPop = 1'b1;
        waitDrain("drainAA");

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
